// File: rtl/minirisc_pkg.sv
// Shared definitions for the minirisc accumulator core.
// Holds datapath sizes, the 4-bit opcode map and the FSM state type.
package minirisc_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned REG_N  = 4;
  localparam int unsigned OP_W   = 4;

  localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OP_W-1:0] OP_LDI  = 4'h1;
  localparam logic [OP_W-1:0] OP_ADDI = 4'h2;
  localparam logic [OP_W-1:0] OP_SUBI = 4'h3;
  localparam logic [OP_W-1:0] OP_ANDI = 4'h4;
  localparam logic [OP_W-1:0] OP_ORI  = 4'h5;
  localparam logic [OP_W-1:0] OP_XORI = 4'h6;
  localparam logic [OP_W-1:0] OP_ST   = 4'h7;
  localparam logic [OP_W-1:0] OP_LD   = 4'h8;
  localparam logic [OP_W-1:0] OP_ADD  = 4'h9;
  localparam logic [OP_W-1:0] OP_SUB  = 4'hA;
  localparam logic [OP_W-1:0] OP_SHL  = 4'hB;
  localparam logic [OP_W-1:0] OP_SHR  = 4'hC;
  localparam logic [OP_W-1:0] OP_NOT  = 4'hD;
  localparam logic [OP_W-1:0] OP_GETF = 4'hE;
  localparam logic [OP_W-1:0] OP_HALT = 4'hF;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

endpackage

// File: rtl/minirisc_alu.sv
// Combinational ALU: computes the next accumulator value and carry.
// Ports: op (opcode), acc (accumulator), operand (imm or R[r]), c_in (carry)
//        -> result_c (new ACC), c_next_c (new carry).
// Opcodes that do not touch ACC or C pass them through unchanged.
module minirisc_alu
  import minirisc_pkg::*;
(
  input  logic [3:0] op,
  input  logic [7:0] acc,
  input  logic [7:0] operand,
  input  logic       c_in,
  output logic [7:0] result_c,
  output logic       c_next_c
);

  logic [8:0] sum;
  logic [8:0] diff;

  // Ninth bit of the widened add is carry-out, of the widened subtract is borrow.
  assign sum  = {1'b0, acc} + {1'b0, operand};
  assign diff = {1'b0, acc} - {1'b0, operand};

  always_comb begin
    result_c = acc;
    c_next_c = c_in;
    case (op)
      OP_LDI, OP_LD:   result_c = operand;
      OP_ADDI, OP_ADD: begin
        result_c = sum[7:0];
        c_next_c = sum[8];
      end
      OP_SUBI, OP_SUB: begin
        result_c = diff[7:0];
        c_next_c = diff[8];
      end
      OP_ANDI: result_c = acc & operand;
      OP_ORI:  result_c = acc | operand;
      OP_XORI: result_c = acc ^ operand;
      OP_SHL: begin
        result_c = {acc[6:0], 1'b0};
        c_next_c = acc[7];
      end
      OP_SHR: begin
        result_c = {1'b0, acc[7:1]};
        c_next_c = acc[0];
      end
      OP_NOT:  result_c = ~acc;
      default: ;
    endcase
  end

endmodule

// File: rtl/tt_um_minirisc.sv
// Tiny accumulator CPU: one instruction per enabled clock, fully executed
// on the edge it is sampled.
// Ports: clk, rst_n (sync, active-low), ena (execute enable),
//        ui_in (instruction: [7:4] opcode, [1:0] register index),
//        uio_in (immediate), uo_out (registered ACC),
//        uio_out / uio_oe (tied to zero, uio pins are inputs only).
module tt_um_minirisc
  import minirisc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_t      state, state_next;
  logic [7:0]  acc, acc_next;
  logic [7:0]  regs [REG_N];
  logic        c, c_next;
  logic        z, z_next;
  logic        reg_we;

  logic [3:0]  op;
  logic [1:0]  r;
  logic        uses_imm;
  logic [7:0]  operand;
  logic [7:0]  alu_res;
  logic        alu_c;
  logic        unused_bits;

  assign op  = ui_in[7:4];
  assign r   = ui_in[1:0];
  assign unused_bits = &{1'b0, ui_in[3:2]};

  // Opcodes 1..6 take the immediate; everything else uses R[r].
  assign uses_imm = (op >= OP_LDI) && (op <= OP_XORI);
  assign operand  = uses_imm ? uio_in : regs[r];

  minirisc_alu u_alu (
    .op       (op),
    .acc      (acc),
    .operand  (operand),
    .c_in     (c),
    .result_c (alu_res),
    .c_next_c (alu_c)
  );

  // Next-state and decode.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    c_next     = c;
    z_next     = z;
    reg_we     = 1'b0;
    if (ena && (state == ST_RUN)) begin
      case (op)
        OP_NOP:  ;
        OP_ST:   reg_we = 1'b1;
        OP_GETF: acc_next = {6'b0, c, z};
        OP_HALT: state_next = ST_HALTED;
        default: begin
          acc_next = alu_res;
          c_next   = alu_c;
          z_next   = (alu_res == 8'h00);
        end
      endcase
    end
  end

  // State registers; reset wins over ena and HALTED.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_RUN;
      acc   <= 8'h00;
      c     <= 1'b0;
      z     <= 1'b1;
      for (int i = 0; i < REG_N; i++) regs[i] <= 8'h00;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      c     <= c_next;
      z     <= z_next;
      if (reg_we) regs[r] <= acc;
    end
  end

  assign uo_out  = acc;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_minirisc.sv
// Self-checking bench for tt_um_minirisc: instruction vectors from a table
// plus hand-written halt / enable / reset sequences, checked via a queue.
module tb_tt_um_minirisc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] ui;
    logic [7:0] uio;
    logic       en;
    logic       rst;
    logic [7:0] exp;
    string      name;
  } vec_t;

  typedef struct {
    logic [7:0] exp;
    string      name;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];

  tt_um_minirisc dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic [7:0] ui, input logic [7:0] uio,
                              input logic en, input logic rst,
                              input logic [7:0] exp, input string name);
    vec_t v;
    v.ui = ui; v.uio = uio; v.en = en; v.rst = rst; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endfunction

  // Drive one cycle, queue its expected ACC, then compare after the edge.
  task automatic step(input logic [7:0] ui, input logic [7:0] uio,
                      input logic en, input logic rst,
                      input logic [7:0] exp, input string name);
    sb_t e;
    @(negedge clk);
    ui_in = ui; uio_in = uio; ena = en; rst_n = rst;
    e.exp = exp; e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      checks++;
      if (uo_out !== e.exp) begin
        failures++;
        $display("FAIL %s: uo_out got %02h expected %02h", e.name, uo_out, e.exp);
      end
    end
    checks++;
    if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
      failures++;
      $display("FAIL %s_uio: uio_out=%02h uio_oe=%02h expected 00/00", name, uio_out, uio_oe);
    end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;

    // Reset and NOP stream
    add(8'h10, 8'h5A, 1, 0, 8'h00, "reset");
    for (int i = 1; i <= 9; i++) add(8'(i), 8'(i), 1, 1, 8'h00, "nop");
    add(8'h00, 8'h00, 1, 1, 8'h00, "nop0");
    add(8'hE0, 8'h00, 1, 1, 8'h01, "getf_reset_z");
    // Add with carry
    add(8'h10, 8'h3C, 1, 1, 8'h3C, "ldi3c");
    add(8'h20, 8'hD0, 1, 1, 8'h0C, "addi_carry");
    add(8'hE0, 8'h00, 1, 1, 8'h02, "getf_c1z0");
    // Store / add register
    add(8'h10, 8'h05, 1, 1, 8'h05, "ldi05");
    add(8'h72, 8'h00, 1, 1, 8'h05, "st_r2");
    add(8'h10, 8'h00, 1, 1, 8'h00, "ldi00");
    add(8'h92, 8'h00, 1, 1, 8'h05, "add_r2");
    add(8'hE0, 8'h00, 1, 1, 8'h00, "getf_c0z0");
    // Borrow and shift carry
    add(8'h10, 8'h03, 1, 1, 8'h03, "ldi03");
    add(8'h30, 8'h05, 1, 1, 8'hFE, "subi_borrow");
    add(8'hE0, 8'h00, 1, 1, 8'h02, "getf_borrow");
    add(8'h10, 8'h80, 1, 1, 8'h80, "ldi80");
    add(8'hB0, 8'h00, 1, 1, 8'h00, "shl");
    add(8'hE0, 8'h00, 1, 1, 8'h03, "getf_shl");
    // Logic ops, NOT, SHR
    add(8'h10, 8'hF0, 1, 1, 8'hF0, "ldif0");
    add(8'h40, 8'h3C, 1, 1, 8'h30, "andi");
    add(8'h50, 8'h0F, 1, 1, 8'h3F, "ori");
    add(8'h60, 8'hFF, 1, 1, 8'hC0, "xori");
    add(8'hD0, 8'h00, 1, 1, 8'h3F, "not");
    add(8'hC0, 8'h00, 1, 1, 8'h1F, "shr");
    add(8'hE0, 8'h00, 1, 1, 8'h02, "getf_shr");
    add(8'h10, 8'h01, 1, 1, 8'h01, "ldi01");
    add(8'hC0, 8'h00, 1, 1, 8'h00, "shr_to_zero");
    add(8'hE0, 8'h00, 1, 1, 8'h03, "getf_shr0");
    // Equal subtract: no borrow, zero; add wrap to zero
    add(8'h10, 8'h07, 1, 1, 8'h07, "ldi07");
    add(8'h30, 8'h07, 1, 1, 8'h00, "subi_equal");
    add(8'hE0, 8'h00, 1, 1, 8'h01, "getf_equal");
    add(8'h10, 8'hFF, 1, 1, 8'hFF, "ldiff");
    add(8'h20, 8'h01, 1, 1, 8'h00, "addi_wrap");
    add(8'hE0, 8'h00, 1, 1, 8'h03, "getf_wrap");
    // Register file isolation and register subtract
    add(8'h10, 8'h11, 1, 1, 8'h11, "ldi11");
    add(8'h71, 8'h00, 1, 1, 8'h11, "st_r1");
    add(8'h10, 8'h22, 1, 1, 8'h22, "ldi22");
    add(8'h73, 8'h00, 1, 1, 8'h22, "st_r3");
    add(8'h81, 8'hFF, 1, 1, 8'h11, "ld_r1");
    add(8'h80, 8'h00, 1, 1, 8'h00, "ld_r0");
    add(8'h82, 8'h00, 1, 1, 8'h05, "ld_r2");
    add(8'h83, 8'h00, 1, 1, 8'h22, "ld_r3");
    add(8'hA1, 8'h00, 1, 1, 8'h11, "sub_r1");
    add(8'hE0, 8'h00, 1, 1, 8'h00, "getf_sub");
    add(8'h10, 8'h05, 1, 1, 8'h05, "ldi05b");
    add(8'hA3, 8'h00, 1, 1, 8'hE3, "sub_r3_borrow");
    add(8'hE0, 8'h00, 1, 1, 8'h02, "getf_sub_borrow");
    // ST leaves Z/C alone; ignored ui bits
    add(8'h10, 8'h00, 1, 1, 8'h00, "ldi00b");
    add(8'h72, 8'h00, 1, 1, 8'h00, "st_r2_zero");
    add(8'hE0, 8'h00, 1, 1, 8'h03, "getf_after_st");
    add(8'h82, 8'h00, 1, 1, 8'h00, "ld_r2_zero");
    add(8'h1C, 8'h44, 1, 1, 8'h44, "ldi_ignored_bits");

    foreach (vecs[i])
      step(vecs[i].ui, vecs[i].uio, vecs[i].en, vecs[i].rst, vecs[i].exp, vecs[i].name);

    // Halt freezes everything until reset
    step(8'h10, 8'h55, 1, 1, 8'h55, "ldi55");
    step(8'hF0, 8'h00, 1, 1, 8'h55, "halt");
    step(8'h10, 8'hAA, 1, 1, 8'h55, "halted_ldi");
    step(8'hE0, 8'h00, 1, 1, 8'h55, "halted_getf");
    step(8'h10, 8'hAA, 0, 1, 8'h55, "halted_ena0");
    step(8'h10, 8'hAA, 1, 0, 8'h00, "reset_from_halt");
    step(8'h10, 8'hAA, 1, 1, 8'hAA, "ldiaa_after_reset");

    // ena low holds state
    for (int i = 0; i < 3; i++) step(8'h10, 8'h77, 0, 1, 8'hAA, "ena0_hold");
    step(8'h72, 8'h00, 0, 1, 8'hAA, "ena0_st");
    step(8'h82, 8'h00, 1, 1, 8'h00, "ld_r2_after_ena0_st");
    step(8'h10, 8'h77, 1, 1, 8'h77, "ldi77");

    // Reset mid-stream discards the presented instruction and overrides ena
    step(8'h10, 8'h99, 1, 0, 8'h00, "reset_midstream");
    step(8'hE0, 8'h00, 1, 1, 8'h01, "getf_after_reset");
    step(8'h81, 8'h00, 1, 1, 8'h00, "ld_r1_after_reset");
    step(8'h10, 8'h33, 1, 1, 8'h33, "ldi33");
    step(8'h10, 8'h44, 0, 0, 8'h00, "reset_ena0");

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tt_um_minirisc.md
TT_UM_MINIRISC -- requirements
Module: tt_um_minirisc

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 8 bits and the register file at 4 entries.
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 ena  input  1  execute enable; low = hold all state.
REQ-005 ui_in  input  8  instruction: [7:4] opcode, [3:2] ignored, [1:0] register index r.
REQ-006 uio_in  input  8  8-bit immediate operand imm.
REQ-007 uo_out  output  8  registered accumulator ACC.
REQ-008 uio_out  output  8  constant 8'h00.
REQ-009 uio_oe  output  8  constant 8'h00 (uio pins are inputs only).

Function
REQ-010 State: ACC[7:0], R0..R3[7:0], carry C, zero Z, and a 2-state FSM {RUN, HALTED}.
REQ-011 In RUN with ena=1, one instruction is sampled from ui_in/uio_in per rising edge and fully executed there; the result is on uo_out immediately after that edge (1-cycle latency, no handshake).
REQ-012 Opcodes: 0 NOP; 1 LDI ACC=imm; 2 ADDI ACC=ACC+imm; 3 SUBI ACC=ACC-imm; 4 ANDI; 5 ORI; 6 XORI (each ACC op imm).
REQ-013 Opcodes: 7 ST R[r]=ACC; 8 LD ACC=R[r]; 9 ADD ACC=ACC+R[r]; A SUB ACC=ACC-R[r].
REQ-014 Opcodes: B SHL ACC={ACC[6:0],0}; C SHR ACC={0,ACC[7:1]}; D NOT ACC=~ACC; E GETF ACC={6'b0,C,Z}; F HALT.
REQ-015 Arithmetic is modulo 256; add sets C = carry out of bit 7; subtract sets C = borrow (1 when minuend < subtrahend, unsigned).
REQ-016 SHL sets C = old ACC[7]; SHR sets C = old ACC[0].
REQ-017 Z SHALL be set to (new ACC == 0) by opcodes 1-6, 8-D; GETF, NOP, ST, HALT leave Z unchanged.
REQ-018 C is changed only by 2, 3, 9, A, B, C; all other opcodes leave C unchanged.
REQ-019 ST writes only the addressed register; other registers and ACC are unchanged.
REQ-020 HALT moves FSM RUN->HALTED; in HALTED all instructions are ignored and all state holds until reset.
REQ-021 With ena=0, no state changes in either FSM state, regardless of ui_in.
REQ-022 uio_out and uio_oe are 8'h00 at all times, including during reset.

Reset
REQ-023 When rst_n=0 at a rising edge: ACC=0, R0..R3=0, C=0, Z=1, FSM=RUN; reset overrides ena and HALTED.
REQ-024 Reset asserted mid-stream discards the instruction presented in that cycle; uo_out reads 8'h00 after that edge.

Structure
REQ-025 A shared package minirisc_pkg SHALL hold the 4-bit opcode constants and the FSM state type.
REQ-026 A combinational sub-module minirisc_alu SHALL compute {C_next, result} from opcode, ACC, operand (imm or R[r]) and C; the top holds registers, FSM, and decode.
REQ-027 Unused inputs (ui_in[3:2] and, in the top, uio_in for non-immediate opcodes) SHALL be consumed without functional effect.

Verification
REQ-028 Reset, then ui_in=uio_in=01,02,...,09,00 on successive cycles (all NOPs) -> uo_out stays 00 throughout.
REQ-029 LDI (ui 10, uio 3C) -> uo_out 3C; ADDI (ui 20, uio D0) -> uo_out 0C; GETF (ui E0) -> uo_out 02 (C=1, Z=0).
REQ-030 LDI 05, ST R2 (ui 72), LDI 00, ADD R2 (ui 92) -> uo_out 05; GETF -> 00.
REQ-031 LDI 03, SUBI 05 (ui 30, uio 05) -> uo_out FE; GETF -> 02; LDI 80, SHL (ui B0) -> 00; GETF -> 03.
REQ-032 LDI 55, HALT (ui F0), LDI AA -> uo_out stays 55; rst_n low one cycle -> 00; LDI AA -> AA.
REQ-033 ena=0 with LDI 77 presented for 3 cycles -> uo_out unchanged; uio_out=uio_oe=00 throughout all scenarios.
